led_pattern_sequencer: RTL and testbench

//   Board-level controller that owns the 4 user LEDs on the 100 MHz design.
//   It debounces the 4 slide switches and decodes them into a display mode.
//   It then sequences the LED output through the pattern for that mode.
//   It sits between the switch pins and the LED pins in top; nothing else drives led.
//

---
 rtl/led_pattern_sequencer.sv | 136 +++++++++++++
 tb/tb_led_pattern_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Debounces the 4 slide switches, decodes a priority display mode and steps the LEDs
// through that mode's pattern once per prescaler period.

module led_sw_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_s,
   output logic sw_db
);
   localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

   logic [CW-1:0] cnt;

   // Accept on the cycle the run length reaches DEBOUNCE_CYC, so sw_db moves
   // DEBOUNCE_CYC+2 edges after a clean pin change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         sw_db <= 1'b0;
      end else if (sw_s == sw_db) begin
         cnt   <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
         sw_db <= sw_s;
         cnt   <= '0;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end
endmodule

module led_pattern_sequencer #(
   parameter int TICK_DIV     = 10_000_000,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   output logic [3:0] led,
   output logic [2:0] mode,
   output logic       tick
);
   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BLINK  = 3'd1,
      CHASE  = 3'd2,
      BOUNCE = 3'd3,
      COUNT  = 3'd4
   } mode_t;

   logic [3:0]    sw_m, sw_s, sw_db;
   mode_t         mode_q, mode_d;
   logic [3:0]    led_d;
   logic          dir_dn, dir_dn_d;
   logic [PW-1:0] presc, presc_d;
   logic          tick_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_m <= '0;
         sw_s <= '0;
      end else begin
         sw_m <= sw;
         sw_s <= sw_m;
      end
   end

   led_sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db [3:0] (
      .clk   (clk),
      .rst   (rst),
      .sw_s  (sw_s),
      .sw_db (sw_db)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= IDLE;
         led    <= '0;
         dir_dn <= 1'b0;
         presc  <= '0;
         tick   <= 1'b0;
      end else begin
         mode_q <= mode_d;
         led    <= led_d;
         dir_dn <= dir_dn_d;
         presc  <= presc_d;
         tick   <= tick_d;
      end
   end

   always_comb begin
      mode_d   = IDLE;
      led_d    = led;
      dir_dn_d = dir_dn;
      presc_d  = presc + 1'b1;
      tick_d   = 1'b0;
      if      (sw_db[3]) mode_d = COUNT;
      else if (sw_db[2]) mode_d = BOUNCE;
      else if (sw_db[1]) mode_d = CHASE;
      else if (sw_db[0]) mode_d = BLINK;
      // A mode change outranks a prescaler wrap on the same edge.
      if (mode_d != mode_q) begin
         presc_d  = '0;
         dir_dn_d = 1'b0;
         case (mode_d)
            BLINK:   led_d = 4'b1111;
            CHASE:   led_d = 4'b0001;
            BOUNCE:  led_d = 4'b0001;
            default: led_d = 4'b0000;
         endcase
      end else if (presc == PW'(TICK_DIV - 1)) begin
         presc_d = '0;
         tick_d  = 1'b1;
         case (mode_q)
            BLINK:   led_d = ~led;
            CHASE:   led_d = {led[2:0], led[3]};
            BOUNCE: begin
               if (!dir_dn) begin
                  if (led[3]) begin led_d = led >> 1; dir_dn_d = 1'b1; end
                  else        led_d = led << 1;
               end else begin
                  if (led[0]) begin led_d = led << 1; dir_dn_d = 1'b0; end
                  else        led_d = led >> 1;
               end
            end
            COUNT:   led_d = led + 4'd1;
            default: led_d = 4'b0000;
         endcase
      end
   end

   assign mode = mode_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a scoreboard of expected LED steps.

module tb_led_pattern_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw;
   logic [3:0] led;
   logic [2:0] mode;
   logic       tick;

   int tests = 0;
   int fails = 0;
   logic [3:0] exp_q[$];

   led_pattern_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYC(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw),
      .led  (led),
      .mode (mode),
      .tick (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait for the next tick, check its spacing and pop the expected LED value.
   task automatic wait_tick(input string tag, input int spacing);
      int n = 0;
      logic [3:0] e;
      do begin
         @(negedge clk);
         n++;
      end while (!tick && n < 12);
      chk({tag, "_tick"}, {7'd0, tick}, 8'd1);
      chk({tag, "_gap"}, 8'(n), 8'(spacing));
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'd1, 8'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_led"}, {4'd0, led}, {4'd0, e});
      end
   endtask

   task automatic wait_mode(input string tag, input logic [2:0] m, input logic [3:0] l);
      repeat (5) @(negedge clk);
      chk({tag, "_mode_early"}, {5'd0, mode}, 8'(dut.mode_q == m ? 3'd7 : mode));
      @(negedge clk);
      chk({tag, "_mode"}, {5'd0, mode}, {5'd0, m});
      chk({tag, "_init"}, {4'd0, led}, {4'd0, l});
   endtask

   initial begin
      logic [2:0] prev_mode;
      rst = 1'b1;
      sw  = 4'b0000;
      // 1: reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rst_led", {4'd0, led}, 8'd0);
         chk("rst_mode", {5'd0, mode}, 8'd0);
         chk("rst_tick", {7'd0, tick}, 8'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_led", {4'd0, led}, 8'd0);
      chk("post_rst_mode", {5'd0, mode}, 8'd0);
      chk("post_rst_tick", {7'd0, tick}, 8'd0);

      // 2: short glitch rejected
      sw = 4'b0010;
      repeat (2) @(negedge clk);
      sw = 4'b0000;
      repeat (10) @(negedge clk);
      chk("glitch_mode", {5'd0, mode}, 8'd0);
      chk("glitch_led", {4'd0, led}, 8'd0);

      // 3: CHASE
      sw = 4'b0010;
      prev_mode = mode;
      repeat (5) @(negedge clk);
      chk("chase_mode_early", {5'd0, mode}, {5'd0, prev_mode});
      @(negedge clk);
      chk("chase_mode", {5'd0, mode}, 8'd2);
      chk("chase_init", {4'd0, led}, 8'h01);
      chk("chase_tick0", {7'd0, tick}, 8'd0);
      exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
      for (int i = 0; i < 4; i++) wait_tick("chase", 4);

      // 4: BOUNCE (bit1 falls and bit2 rises together)
      sw = 4'b0100;
      prev_mode = mode;
      repeat (5) @(negedge clk);
      chk("bounce_mode_early", {5'd0, mode}, {5'd0, prev_mode});
      @(negedge clk);
      chk("bounce_mode", {5'd0, mode}, 8'd3);
      chk("bounce_init", {4'd0, led}, 8'h01);
      exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      for (int i = 0; i < 7; i++) wait_tick("bounce", 4);

      // 5: COUNT with wrap, then higher-priority bits added without reload
      sw = 4'b1000;
      repeat (6) @(negedge clk);
      chk("count_mode", {5'd0, mode}, 8'd4);
      chk("count_init", {4'd0, led}, 8'h00);
      for (int v = 1; v <= 16; v++) exp_q.push_back(4'(v));
      for (int i = 0; i < 16; i++) wait_tick("count", 4);
      sw = 4'b1111;
      for (int v = 1; v <= 3; v++) exp_q.push_back(4'(v));
      for (int i = 0; i < 3; i++) wait_tick("prio", 4);
      chk("prio_mode", {5'd0, mode}, 8'd4);
      exp_q.push_back(4'd4); exp_q.push_back(4'd5);
      for (int i = 0; i < 2; i++) wait_tick("count2", 4);

      // 6: asynchronous reset mid-COUNT
      chk("pre_rst_led", {4'd0, led}, 8'h05);
      rst = 1'b1;
      #1;
      chk("async_led", {4'd0, led}, 8'd0);
      chk("async_mode", {5'd0, mode}, 8'd0);
      chk("async_tick", {7'd0, tick}, 8'd0);
      sw = 4'b1000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("reentry_mode_early", {5'd0, mode}, 8'd0);
      @(negedge clk);
      chk("reentry_mode", {5'd0, mode}, 8'd4);
      chk("reentry_led", {4'd0, led}, 8'd0);
      exp_q.push_back(4'd1);
      wait_tick("reentry", 4);
      chk("sb_drained", 8'(exp_q.size()), 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
